// File: rtl/ir_key_decode_pkg.sv
// Shared definitions for the NEC key decoder: state codes, frame field
// positions and the frame integrity check.
package ir_key_decode_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  // NEC frame field positions within the 32-bit capture word
  localparam int ADDR_MSB  = 31;
  localparam int ADDR_LSB  = 24;
  localparam int NADDR_MSB = 23;
  localparam int NADDR_LSB = 16;
  localparam int CMD_MSB   = 15;
  localparam int CMD_LSB   = 8;
  localparam int NCMD_MSB  = 7;
  localparam int NCMD_LSB  = 0;

  // A byte XORed with its transmitted inverse yields all ones
  localparam logic [7:0] NEC_INV_OK = 8'hFF;

  // Command must always match its inverse; the address inverse is only
  // checked for classic (8-bit address) NEC.
  function automatic logic frame_ok(input logic [31:0] d, input logic ext);
    logic cmd_ok;
    logic addr_ok;
    cmd_ok  = (d[CMD_MSB:CMD_LSB] ^ d[NCMD_MSB:NCMD_LSB]) == NEC_INV_OK;
    addr_ok = ext | ((d[ADDR_MSB:ADDR_LSB] ^ d[NADDR_MSB:NADDR_LSB]) == NEC_INV_OK);
    return cmd_ok & addr_ok;
  endfunction

endpackage

// File: rtl/ir_key_decode_if.sv
// Bundle between the IR receiver side and the key decoder.
//
// Handshake: there is no back-pressure. i_data_vld and i_rpt are one-cycle
// strobes; the decoder samples them on every clk edge and never stalls.
// i_data is only meaningful in a cycle where i_data_vld is high. Every o_*
// signal is registered and reflects the strobe seen one clk earlier;
// o_key_vld, o_release and o_err are one-cycle pulses, o_held is a level.
interface ir_key_decode_if;
  import ir_key_decode_pkg::*;

  logic [31:0] i_data;
  logic        i_data_vld;
  logic        i_rpt;
  logic [15:0] o_addr;
  logic [7:0]  o_cmd;
  logic        o_key_vld;
  logic        o_key_rpt;
  logic        o_held;
  logic        o_release;
  logic        o_err;
  logic [7:0]  o_err_cnt;
  state_t      o_state;

  modport master (
    output i_data, i_data_vld, i_rpt,
    input  o_addr, o_cmd, o_key_vld, o_key_rpt, o_held,
           o_release, o_err, o_err_cnt, o_state
  );

  modport slave (
    input  i_data, i_data_vld, i_rpt,
    output o_addr, o_cmd, o_key_vld, o_key_rpt, o_held,
           o_release, o_err, o_err_cnt, o_state
  );

endinterface

// File: rtl/ir_key_decode_hold_timer.sv
// Hold timeout counter: counts cycles while enabled, sticks at the last
// count instead of wrapping, and flags expiry while enabled at that count.
module ir_key_decode_hold_timer #(
  parameter int unsigned TO_CYC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [31:0] LP_LAST = 32'(TO_CYC - 1);

  logic [31:0] r_cnt;

  // Count up while enabled; clear has priority, saturate at the last count
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LP_LAST)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_expire = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/ir_key_decode.sv
// NEC key decoder: validates captured frames, emits fresh-press and
// auto-repeat key events, releases a held key when repeats stop, and
// counts integrity errors.
module ir_key_decode
  import ir_key_decode_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int HOLD_MS   = 120,
  parameter int RPT_START = 4,
  parameter int EXT_ADDR  = 0
) (
  input  logic             clk,
  input  logic             rst,
  ir_key_decode_if.slave   bus
);

  localparam int unsigned TO_CYC       = 32'((CLK_HZ / 1000) * HOLD_MS);
  localparam logic        LP_EXT       = (EXT_ADDR != 0);
  localparam logic [7:0]  LP_RPT_START = 8'(RPT_START);

  state_t      r_state;
  logic [15:0] r_addr;
  logic [7:0]  r_cmd;
  logic        r_key_vld;
  logic        r_key_rpt;
  logic        r_release;
  logic        r_err;
  logic [7:0]  r_err_cnt;
  logic [7:0]  r_rpt_cnt;

  state_t      w_state_nxt;
  logic [15:0] w_addr_nxt;
  logic [7:0]  w_cmd_nxt;
  logic        w_key_vld_nxt;
  logic        w_key_rpt_nxt;
  logic        w_release_nxt;
  logic        w_err_nxt;
  logic [7:0]  w_rpt_cnt_nxt;
  logic [7:0]  w_rpt_inc;
  logic        w_timer_clr;
  logic        w_expire;
  logic        w_frame_ok;
  logic [15:0] w_frame_addr;

  assign w_frame_ok   = frame_ok(bus.i_data, LP_EXT);
  assign w_frame_addr = LP_EXT ? bus.i_data[31:16]
                               : {8'h00, bus.i_data[ADDR_MSB:ADDR_LSB]};
  assign w_rpt_inc    = (r_rpt_cnt < LP_RPT_START) ? (r_rpt_cnt + 8'd1) : r_rpt_cnt;

  ir_key_decode_hold_timer #(
    .TO_CYC (TO_CYC)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_timer_clr),
    .i_en     (r_state == ST_HELD),
    .o_expire (w_expire)
  );

  // Next-state and next-output decode; data beats repeat, any strobe beats timeout
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_cmd_nxt     = r_cmd;
    w_key_vld_nxt = 1'b0;
    w_key_rpt_nxt = 1'b0;
    w_release_nxt = 1'b0;
    w_err_nxt     = 1'b0;
    w_rpt_cnt_nxt = r_rpt_cnt;
    w_timer_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_clr = 1'b1;
        if (bus.i_data_vld) begin
          if (w_frame_ok) begin
            w_addr_nxt    = w_frame_addr;
            w_cmd_nxt     = bus.i_data[CMD_MSB:CMD_LSB];
            w_key_vld_nxt = 1'b1;
            w_rpt_cnt_nxt = 8'd0;
            w_state_nxt   = ST_HELD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (bus.i_data_vld) begin
          w_timer_clr = 1'b1;
          if (w_frame_ok) begin
            w_addr_nxt    = w_frame_addr;
            w_cmd_nxt     = bus.i_data[CMD_MSB:CMD_LSB];
            w_key_vld_nxt = 1'b1;
            w_rpt_cnt_nxt = 8'd0;
          end else begin
            w_err_nxt     = 1'b1;
            w_rpt_cnt_nxt = 8'd0;
            w_state_nxt   = ST_IDLE;
          end
        end else if (bus.i_rpt) begin
          w_timer_clr   = 1'b1;
          w_rpt_cnt_nxt = w_rpt_inc;
          if (w_rpt_inc >= LP_RPT_START) begin
            w_key_vld_nxt = 1'b1;
            w_key_rpt_nxt = 1'b1;
          end
        end else if (w_expire) begin
          w_release_nxt = 1'b1;
          w_rpt_cnt_nxt = 8'd0;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides any concurrent strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_cmd     <= '0;
      r_key_vld <= 1'b0;
      r_key_rpt <= 1'b0;
      r_release <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_rpt_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_cmd     <= w_cmd_nxt;
      r_key_vld <= w_key_vld_nxt;
      r_key_rpt <= w_key_rpt_nxt;
      r_release <= w_release_nxt;
      r_err     <= w_err_nxt;
      r_rpt_cnt <= w_rpt_cnt_nxt;
      if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus.o_addr    = r_addr;
  assign bus.o_cmd     = r_cmd;
  assign bus.o_key_vld = r_key_vld;
  assign bus.o_key_rpt = r_key_rpt;
  assign bus.o_held    = (r_state == ST_HELD);
  assign bus.o_release = r_release;
  assign bus.o_err     = r_err;
  assign bus.o_err_cnt = r_err_cnt;
  assign bus.o_state   = r_state;

endmodule

// File: tb/tb_ir_key_decode.sv
// Directed bench for ir_key_decode with a 10-cycle hold timeout.
// dut0 runs classic NEC addressing, dut1 extended addressing.
module tb_ir_key_decode;
  import ir_key_decode_pkg::*;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  ir_key_decode_if bus0();
  ir_key_decode_if bus1();

  ir_key_decode #(.CLK_HZ(1000), .HOLD_MS(10), .RPT_START(4), .EXT_ADDR(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  ir_key_decode #(.CLK_HZ(1000), .HOLD_MS(10), .RPT_START(4), .EXT_ADDR(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: apply a strobe for one cycle; return 1 time unit after
  // the capturing edge, when the registered response is visible
  task automatic strobe0(input logic [31:0] d, input logic v, input logic r);
    @(posedge clk); #1;
    bus0.i_data = d; bus0.i_data_vld = v; bus0.i_rpt = r;
    @(posedge clk); #1;
    bus0.i_data_vld = 1'b0; bus0.i_rpt = 1'b0;
  endtask

  task automatic strobe1(input logic [31:0] d, input logic v, input logic r);
    @(posedge clk); #1;
    bus1.i_data = d; bus1.i_data_vld = v; bus1.i_rpt = r;
    @(posedge clk); #1;
    bus1.i_data_vld = 1'b0; bus1.i_rpt = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    n_total++; if (bus0.o_state !== ST_IDLE) begin n_bad++; $display("FAIL reset_state got=%0d want=%0d", bus0.o_state, ST_IDLE); end
    n_total++; if (bus0.o_addr !== 16'h0000 || bus0.o_cmd !== 8'h00) begin n_bad++; $display("FAIL reset_addr_cmd got=%h/%h want=0000/00", bus0.o_addr, bus0.o_cmd); end
    n_total++; if ({bus0.o_key_vld, bus0.o_key_rpt, bus0.o_held, bus0.o_release, bus0.o_err} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got=%b want=00000", {bus0.o_key_vld, bus0.o_key_rpt, bus0.o_held, bus0.o_release, bus0.o_err}); end
    n_total++; if (bus0.o_err_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_err_cnt got=%h want=00", bus0.o_err_cnt); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_press;
    strobe0(32'h00FF_A25D, 1'b1, 1'b0);
    n_total++; if (bus0.o_key_vld !== 1'b1 || bus0.o_key_rpt !== 1'b0) begin n_bad++; $display("FAIL press_key got=%b%b want=10", bus0.o_key_vld, bus0.o_key_rpt); end
    n_total++; if (bus0.o_cmd !== 8'hA2 || bus0.o_addr !== 16'h0000) begin n_bad++; $display("FAIL press_code got=%h/%h want=0000/A2", bus0.o_addr, bus0.o_cmd); end
    n_total++; if (bus0.o_held !== 1'b1) begin n_bad++; $display("FAIL press_held got=%b want=1", bus0.o_held); end
    idle(1);
    n_total++; if (bus0.o_key_vld !== 1'b0) begin n_bad++; $display("FAIL press_pulse got=%b want=0", bus0.o_key_vld); end
  endtask

  task automatic test_repeat;
    logic want;
    idle(2);
    for (int i = 1; i <= 5; i++) begin
      idle(3);
      strobe0(32'h0, 1'b0, 1'b1);
      want = (i >= 4);
      n_total++; if (bus0.o_key_vld !== want || bus0.o_key_rpt !== want) begin n_bad++; $display("FAIL rpt_event_%0d got=%b%b want=%b%b", i, bus0.o_key_vld, bus0.o_key_rpt, want, want); end
      n_total++; if (bus0.o_held !== 1'b1 || bus0.o_cmd !== 8'hA2) begin n_bad++; $display("FAIL rpt_held_%0d got=%b/%h want=1/A2", i, bus0.o_held, bus0.o_cmd); end
    end
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      want = (k == 10);
      n_total++; if (bus0.o_release !== want || bus0.o_held !== !want) begin n_bad++; $display("FAIL rpt_release_k%0d got=%b/%b want=%b/%b", k, bus0.o_release, bus0.o_held, want, !want); end
    end
    idle(1);
    n_total++; if (bus0.o_release !== 1'b0 || bus0.o_state !== ST_IDLE) begin n_bad++; $display("FAIL release_pulse got=%b/%0d want=0/0", bus0.o_release, bus0.o_state); end
  endtask

  task automatic test_err;
    strobe0(32'h00FF_A25C, 1'b1, 1'b0);
    n_total++; if (bus0.o_err !== 1'b1 || bus0.o_err_cnt !== 8'h01) begin n_bad++; $display("FAIL err_first got=%b/%h want=1/01", bus0.o_err, bus0.o_err_cnt); end
    n_total++; if (bus0.o_key_vld !== 1'b0 || bus0.o_held !== 1'b0) begin n_bad++; $display("FAIL err_nokey got=%b/%b want=0/0", bus0.o_key_vld, bus0.o_held); end
    strobe0(32'h01FF_A25D, 1'b1, 1'b0);
    n_total++; if (bus0.o_err !== 1'b1 || bus0.o_err_cnt !== 8'h02) begin n_bad++; $display("FAIL err_addr got=%b/%h want=1/02", bus0.o_err, bus0.o_err_cnt); end
    for (int i = 0; i < 298; i++) strobe0(32'h00FF_A25C, 1'b1, 1'b0);
    n_total++; if (bus0.o_err_cnt !== 8'hFF) begin n_bad++; $display("FAIL err_sat got=%h want=FF", bus0.o_err_cnt); end
    // bad frame while held: error, back to idle, no release
    strobe0(32'h00FF_A25D, 1'b1, 1'b0);
    strobe0(32'h00FF_A2A2, 1'b1, 1'b0);
    n_total++; if (bus0.o_err !== 1'b1 || bus0.o_held !== 1'b0 || bus0.o_release !== 1'b0 || bus0.o_key_vld !== 1'b0) begin n_bad++; $display("FAIL err_held got=%b%b%b%b want=1000", bus0.o_err, bus0.o_held, bus0.o_release, bus0.o_key_vld); end
    n_total++; if (bus0.o_err_cnt !== 8'hFF) begin n_bad++; $display("FAIL err_sat_hold got=%h want=FF", bus0.o_err_cnt); end
  endtask

  task automatic test_orphan_rpt;
    strobe0(32'h0, 1'b0, 1'b1);
    n_total++; if ({bus0.o_key_vld, bus0.o_held, bus0.o_release, bus0.o_err} !== 4'b0) begin n_bad++; $display("FAIL orphan_flags got=%b want=0000", {bus0.o_key_vld, bus0.o_held, bus0.o_release, bus0.o_err}); end
    n_total++; if (bus0.o_cmd !== 8'hA2 || bus0.o_err_cnt !== 8'hFF) begin n_bad++; $display("FAIL orphan_regs got=%h/%h want=A2/FF", bus0.o_cmd, bus0.o_err_cnt); end
  endtask

  task automatic test_back_to_back;
    strobe0(32'h00FF_A25D, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) strobe0(32'h0, 1'b0, 1'b1);
    // data and repeat together: fresh press wins and restarts the repeat count
    strobe0(32'h00FF_18E7, 1'b1, 1'b1);
    n_total++; if (bus0.o_key_vld !== 1'b1 || bus0.o_key_rpt !== 1'b0 || bus0.o_cmd !== 8'h18) begin n_bad++; $display("FAIL simul_press got=%b%b/%h want=10/18", bus0.o_key_vld, bus0.o_key_rpt, bus0.o_cmd); end
    strobe0(32'h0, 1'b0, 1'b1);
    n_total++; if (bus0.o_key_vld !== 1'b0) begin n_bad++; $display("FAIL simul_rptcnt got=%b want=0", bus0.o_key_vld); end
    for (int i = 0; i < 3; i++) strobe0(32'h0, 1'b0, 1'b1);
    n_total++; if (bus0.o_key_vld !== 1'b1 || bus0.o_key_rpt !== 1'b1 || bus0.o_cmd !== 8'h18) begin n_bad++; $display("FAIL simul_4th got=%b%b/%h want=11/18", bus0.o_key_vld, bus0.o_key_rpt, bus0.o_cmd); end
    // same code again while held is still a fresh press
    strobe0(32'h00FF_18E7, 1'b1, 1'b0);
    n_total++; if (bus0.o_key_vld !== 1'b1 || bus0.o_key_rpt !== 1'b0) begin n_bad++; $display("FAIL same_code got=%b%b want=10", bus0.o_key_vld, bus0.o_key_rpt); end
  endtask

  task automatic test_timeout_edge;
    int rel_at;
    strobe0(32'h00FF_A25D, 1'b1, 1'b0);
    idle(8);
    strobe0(32'h0, 1'b0, 1'b1);
    n_total++; if (bus0.o_release !== 1'b0 || bus0.o_held !== 1'b1) begin n_bad++; $display("FAIL edge_norelease got=%b/%b want=0/1", bus0.o_release, bus0.o_held); end
    rel_at = 0;
    for (int k = 1; k <= 14 && rel_at == 0; k++) begin
      idle(1);
      if (bus0.o_release === 1'b1) rel_at = k;
    end
    n_total++; if (rel_at != 10) begin n_bad++; $display("FAIL edge_release_at got=%0d want=10", rel_at); end
  endtask

  task automatic test_ext;
    strobe1(32'h1234_18E7, 1'b1, 1'b0);
    n_total++; if (bus1.o_addr !== 16'h1234 || bus1.o_cmd !== 8'h18) begin n_bad++; $display("FAIL ext_code got=%h/%h want=1234/18", bus1.o_addr, bus1.o_cmd); end
    n_total++; if (bus1.o_key_vld !== 1'b1 || bus1.o_err !== 1'b0) begin n_bad++; $display("FAIL ext_key got=%b/%b want=1/0", bus1.o_key_vld, bus1.o_err); end
    strobe1(32'h1234_18E6, 1'b1, 1'b0);
    n_total++; if (bus1.o_err !== 1'b1 || bus1.o_err_cnt !== 8'h01 || bus1.o_addr !== 16'h1234) begin n_bad++; $display("FAIL ext_err got=%b/%h/%h want=1/01/1234", bus1.o_err, bus1.o_err_cnt, bus1.o_addr); end
    strobe0(32'h1234_18E7, 1'b1, 1'b0);
    n_total++; if (bus0.o_err !== 1'b1 || bus0.o_key_vld !== 1'b0) begin n_bad++; $display("FAIL classic_addr_err got=%b/%b want=1/0", bus0.o_err, bus0.o_key_vld); end
  endtask

  task automatic test_reset_mid;
    strobe0(32'h00FF_A25D, 1'b1, 1'b0);
    n_total++; if (bus0.o_held !== 1'b1) begin n_bad++; $display("FAIL mid_held got=%b want=1", bus0.o_held); end
    idle(2);
    @(posedge clk); #1;
    rst = 1'b1; bus0.i_rpt = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus0.i_rpt = 1'b0;
    n_total++; if (bus0.o_state !== ST_IDLE || bus0.o_held !== 1'b0) begin n_bad++; $display("FAIL mid_state got=%0d/%b want=0/0", bus0.o_state, bus0.o_held); end
    n_total++; if ({bus0.o_addr, bus0.o_cmd, bus0.o_err_cnt} !== 32'h0) begin n_bad++; $display("FAIL mid_regs got=%h want=00000000", {bus0.o_addr, bus0.o_cmd, bus0.o_err_cnt}); end
    n_total++; if ({bus0.o_key_vld, bus0.o_key_rpt, bus0.o_release, bus0.o_err} !== 4'b0) begin n_bad++; $display("FAIL mid_flags got=%b want=0000", {bus0.o_key_vld, bus0.o_key_rpt, bus0.o_release, bus0.o_err}); end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b0;
    bus0.i_data = '0; bus0.i_data_vld = 1'b0; bus0.i_rpt = 1'b0;
    bus1.i_data = '0; bus1.i_data_vld = 1'b0; bus1.i_rpt = 1'b0;
    test_reset;
    test_press;
    test_repeat;
    test_err;
    test_orphan_rpt;
    test_back_to_back;
    test_timeout_edge;
    test_ext;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
